// File: rtl/adc_sched_pkg.sv
// Shared defaults and FSM state encoding for the ADC sample scheduler.
package adc_sched_pkg;

    localparam int unsigned NUM_CH_DEF  = 4;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned PERIOD_DEF  = 1000;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DATA = 3'd3,
        S_PUSH      = 3'd4,
        S_NEXT      = 3'd5
    } sched_state_t;

endpackage

// File: rtl/adc_sample_scheduler_if.sv
// Control, SPI-receiver and sample-stream signals of the ADC sample scheduler.
interface adc_sample_scheduler_if #(
    parameter int unsigned NUM_CH = adc_sched_pkg::NUM_CH_DEF,
    parameter int unsigned DATA_W = adc_sched_pkg::DATA_W_DEF
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic              enable;
    logic              clear_err;
    logic              spi_en;
    logic [CH_W-1:0]   ch_sel;
    logic              data_ready;
    logic [DATA_W-1:0] rx_data;
    logic [DATA_W-1:0] sample_data;
    logic [CH_W-1:0]   sample_ch;
    logic              sample_valid;
    logic              sample_ready;
    logic              frame_done;
    logic              busy;
    logic              overrun;
    logic              timeout_err;

    modport slave (
        input  enable, clear_err, data_ready, rx_data, sample_ready,
        output spi_en, ch_sel, sample_data, sample_ch, sample_valid,
               frame_done, busy, overrun, timeout_err
    );

    modport master (
        output enable, clear_err, data_ready, rx_data, sample_ready,
        input  spi_en, ch_sel, sample_data, sample_ch, sample_valid,
               frame_done, busy, overrun, timeout_err
    );

endinterface

// File: rtl/sample_period_timer.sv
// Free-running frame period counter; tick is high while the count sits at PERIOD-1.
module sample_period_timer #(
    parameter int unsigned PERIOD = adc_sched_pkg::PERIOD_DEF
) (
    input  logic clk,
    input  logic reset_b,
    input  logic enable,
    output logic tick
);
    localparam int unsigned CNT_W = $clog2(PERIOD + 1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_tick;

    always_comb begin
        w_count_nxt = '0;
        if (enable && (r_count != CNT_W'(PERIOD - 1))) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    // Tick is decoded from the next count so it stays registered yet aligned with the count.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tick  <= (w_count_nxt == CNT_W'(PERIOD - 1));
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/adc_sample_scheduler.sv
// Round-robin ADC channel sampler: one SPI conversion per channel each frame, streamed out with valid/ready.
module adc_sample_scheduler #(
    parameter int unsigned NUM_CH  = adc_sched_pkg::NUM_CH_DEF,
    parameter int unsigned DATA_W  = adc_sched_pkg::DATA_W_DEF,
    parameter int unsigned PERIOD  = adc_sched_pkg::PERIOD_DEF,
    parameter int unsigned TIMEOUT = adc_sched_pkg::TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   reset_b,
    adc_sample_scheduler_if.slave  bus
);
    import adc_sched_pkg::*;

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic [CH_W-1:0]   r_ch_sel;
    logic [CH_W-1:0]   w_ch_nxt;
    logic [CH_W-1:0]   r_sample_ch;
    logic [CH_W-1:0]   w_sample_ch_nxt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [TMO_W-1:0]  w_tmo_nxt;
    logic [DATA_W-1:0] r_sample_data;
    logic [DATA_W-1:0] w_sample_data_nxt;
    logic              r_spi_en;
    logic              r_sample_valid;
    logic              r_frame_done;
    logic              r_busy;
    logic              r_overrun;
    logic              r_timeout_err;
    logic              w_tick;
    logic              w_done_nxt;
    logic              w_ovr_set;
    logic              w_tmo_set;

    sample_period_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk     (clk),
        .reset_b (reset_b),
        .enable  (bus.enable),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A tick outside WAIT_TICK is dropped and only flagged; frames never queue.
    always_comb begin
        w_state_nxt       = r_state;
        w_ch_nxt          = r_ch_sel;
        w_tmo_nxt         = '0;
        w_sample_data_nxt = r_sample_data;
        w_sample_ch_nxt   = r_sample_ch;
        w_done_nxt        = 1'b0;
        w_tmo_set         = 1'b0;
        w_ovr_set         = w_tick && (r_state != S_WAIT_TICK);

        unique case (r_state)
            S_IDLE: begin
                if (bus.enable) w_state_nxt = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    w_state_nxt = S_START;
                    w_ch_nxt    = '0;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (bus.data_ready) begin
                    w_sample_data_nxt = bus.rx_data;
                    w_sample_ch_nxt   = r_ch_sel;
                    w_state_nxt       = S_PUSH;
                end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    w_tmo_set   = 1'b1;
                    w_state_nxt = S_NEXT;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
                end
            end
            S_PUSH: begin
                if (r_sample_valid && bus.sample_ready) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (r_ch_sel == CH_W'(NUM_CH - 1)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = bus.enable ? S_WAIT_TICK : S_IDLE;
                end else begin
                    w_ch_nxt    = r_ch_sel + CH_W'(1);
                    w_state_nxt = S_START;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_ch_sel       <= '0;
            r_tmo_cnt      <= '0;
            r_sample_data  <= '0;
            r_sample_ch    <= '0;
            r_spi_en       <= 1'b0;
            r_sample_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_ch_sel       <= w_ch_nxt;
            r_tmo_cnt      <= w_tmo_nxt;
            r_sample_data  <= w_sample_data_nxt;
            r_sample_ch    <= w_sample_ch_nxt;
            r_spi_en       <= (w_state_nxt == S_START);
            r_sample_valid <= (w_state_nxt == S_PUSH);
            r_frame_done   <= w_done_nxt;
            r_busy         <= !((w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT_TICK));
            r_overrun      <= w_ovr_set || (r_overrun && !bus.clear_err);
            r_timeout_err  <= w_tmo_set || (r_timeout_err && !bus.clear_err);
        end
    end

    assign bus.spi_en       = r_spi_en;
    assign bus.ch_sel       = r_ch_sel;
    assign bus.sample_data  = r_sample_data;
    assign bus.sample_ch    = r_sample_ch;
    assign bus.sample_valid = r_sample_valid;
    assign bus.frame_done   = r_frame_done;
    assign bus.busy         = r_busy;
    assign bus.overrun      = r_overrun;
    assign bus.timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: modelled SPI responder, sample scoreboard, frame table and corner sequences.
module tb_adc_sample_scheduler;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 16;
    localparam int unsigned LAT = 5;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        int          skip_ch;
        int          stall_ch;
        bit          drop_en;
        logic [15:0] base;
        int          exp_samples;
        bit          exp_tmo;
        bit          exp_ovr;
    } vec_t;

    logic clk = 1'b0;
    logic reset_b;
    always #5 clk = ~clk;

    adc_sample_scheduler_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

    adc_sample_scheduler #(
        .NUM_CH  (NCH),
        .DATA_W  (DW),
        .PERIOD  (20),
        .TIMEOUT (8)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          spi_cnt = 0;
    int          samp_cnt = 0;
    int          fd_cnt = 0;
    int          rsp_ch = 0;
    int          skip_ch = -1;
    int          stall_ch = -1;
    logic [15:0] base = 16'h1000;
    exp_t        sb[$];
    vec_t        vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_spi_en"},       32'(bus.spi_en),       0);
        chk({tag, "_ch_sel"},       32'(bus.ch_sel),       0);
        chk({tag, "_sample_valid"}, 32'(bus.sample_valid), 0);
        chk({tag, "_sample_data"},  32'(bus.sample_data),  0);
        chk({tag, "_sample_ch"},    32'(bus.sample_ch),    0);
        chk({tag, "_frame_done"},   32'(bus.frame_done),   0);
        chk({tag, "_busy"},         32'(bus.busy),         0);
        chk({tag, "_overrun"},      32'(bus.overrun),      0);
        chk({tag, "_timeout_err"},  32'(bus.timeout_err),  0);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 bus.clear_err = 1'b1;
        @(posedge clk); #1 bus.clear_err = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int k = 0;
        while (fd_cnt == 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_frame_done_cnt"}, 32'(fd_cnt), 1);
    endtask

    // SPI receiver model: answers each spi_en after LAT clocks, or stays silent on skip_ch.
    initial begin : responder
        int   ch;
        int   k;
        bit   abort;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_b && bus.spi_en) begin
                chk("ch_sel_order", 32'(bus.ch_sel), 32'(rsp_ch));
                ch     = rsp_ch;
                rsp_ch = (rsp_ch + 1) % NCH;
                if (ch == skip_ch) begin
                    k = 0;
                    while (k < 12 && !bus.timeout_err) begin
                        @(negedge clk);
                        k++;
                    end
                    chk("timeout_latency", 32'(k), 9);
                end else begin
                    abort = 1'b0;
                    repeat (LAT) begin
                        @(posedge clk);
                        if (!reset_b) abort = 1'b1;
                    end
                    if (!abort) begin
                        #1;
                        e.ch   = 2'(ch);
                        e.data = base + 16'(ch);
                        sb.push_back(e);
                        bus.rx_data    = e.data;
                        bus.data_ready = 1'b1;
                        @(posedge clk); #1;
                        bus.data_ready = 1'b0;
                        bus.rx_data    = 16'hDEAD;
                    end
                end
            end
        end
    end

    // Backpressure on stall_ch: sample must hold steady and no new conversion may start.
    initial begin : ready_ctl
        int          k;
        int          spi_seen;
        logic [15:0] hold;
        forever begin
            @(negedge clk);
            if (reset_b && stall_ch >= 0 && bus.spi_en && 32'(bus.ch_sel) == 32'(stall_ch)) begin
                @(posedge clk); #1 bus.sample_ready = 1'b0;
                k = 0;
                while (k < 20 && !bus.sample_valid) begin
                    @(negedge clk);
                    k++;
                end
                chk("stall_valid_seen", 32'(bus.sample_valid), 1);
                hold     = base + 16'(stall_ch);
                spi_seen = 0;
                repeat (10) begin
                    @(negedge clk);
                    chk("stall_valid_hold", 32'(bus.sample_valid), 1);
                    chk("stall_data_hold", 32'(bus.sample_data), 32'(hold));
                    if (bus.spi_en) spi_seen++;
                end
                chk("stall_no_spi_en", 32'(spi_seen), 0);
                @(posedge clk); #1 bus.sample_ready = 1'b1;
            end
        end
    end

    // Output monitor: scoreboard pops on handshake, pulse widths and hold-under-stall checks.
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic        prev_spi = 1'b0;
    logic        prev_fd = 1'b0;
    logic [15:0] prev_d = '0;
    logic [1:0]  prev_c = '0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!reset_b) begin
            prev_v   = 1'b0;
            prev_r   = 1'b0;
            prev_spi = 1'b0;
            prev_fd  = 1'b0;
        end else begin
            if (bus.spi_en) begin
                spi_cnt++;
                chk("spi_en_single_cycle", 32'(prev_spi), 0);
            end
            if (bus.frame_done) begin
                fd_cnt++;
                chk("frame_done_single_cycle", 32'(prev_fd), 0);
            end
            if (prev_v && !prev_r) begin
                chk("hold_valid", 32'(bus.sample_valid), 1);
                chk("hold_data", 32'(bus.sample_data), 32'(prev_d));
                chk("hold_ch", 32'(bus.sample_ch), 32'(prev_c));
            end
            if (bus.sample_valid && bus.sample_ready) begin
                samp_cnt++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sample_unexpected: got ch %0d data 0x%0h, none expected", bus.sample_ch, bus.sample_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sample_data", 32'(bus.sample_data), 32'(mon_e.data));
                    chk("sample_ch", 32'(bus.sample_ch), 32'(mon_e.ch));
                end
            end
            prev_v   = bus.sample_valid;
            prev_r   = bus.sample_ready;
            prev_spi = bus.spi_en;
            prev_fd  = bus.frame_done;
            prev_d   = bus.sample_data;
            prev_c   = bus.sample_ch;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        vecs[0] = '{-1, -1, 1'b0, 16'h1000, 4, 1'b0, 1'b1};
        vecs[1] = '{-1,  1, 1'b0, 16'h1000, 4, 1'b0, 1'b1};
        vecs[2] = '{ 2, -1, 1'b0, 16'h1000, 3, 1'b1, 1'b1};
        vecs[3] = '{-1, -1, 1'b1, 16'h2A50, 4, 1'b0, 1'b0};

        reset_b          = 1'b0;
        bus.enable       = 1'b0;
        bus.clear_err    = 1'b0;
        bus.data_ready   = 1'b0;
        bus.rx_data      = 16'h0;
        bus.sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("por");
        @(posedge clk); #1 reset_b = 1'b1;

        for (int v = 0; v < 4; v++) begin
            skip_ch  = vecs[v].skip_ch;
            stall_ch = vecs[v].stall_ch;
            base     = vecs[v].base;
            pulse_clear();
            @(negedge clk);
            chk($sformatf("v%0d_overrun_cleared", v), 32'(bus.overrun), 0);
            chk($sformatf("v%0d_timeout_cleared", v), 32'(bus.timeout_err), 0);
            spi_cnt  = 0;
            samp_cnt = 0;
            fd_cnt   = 0;
            rsp_ch   = 0;
            @(posedge clk); #1 bus.enable = 1'b1;
            if (vecs[v].drop_en) begin
                k = 0;
                while (spi_cnt == 0 && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                @(posedge clk); #1 bus.enable = 1'b0;
            end
            wait_frame($sformatf("v%0d", v));
            @(posedge clk); #1 bus.enable = 1'b0;
            repeat (6) @(negedge clk);
            chk($sformatf("v%0d_spi_en_count", v), 32'(spi_cnt), 4);
            chk($sformatf("v%0d_sample_count", v), 32'(samp_cnt), 32'(vecs[v].exp_samples));
            chk($sformatf("v%0d_busy_after", v), 32'(bus.busy), 0);
            chk($sformatf("v%0d_timeout_err", v), 32'(bus.timeout_err), 32'(vecs[v].exp_tmo));
            chk($sformatf("v%0d_overrun", v), 32'(bus.overrun), 32'(vecs[v].exp_ovr));
            chk($sformatf("v%0d_sb_drained", v), 32'(sb.size()), 0);
        end

        // Second tick lands mid-frame; clear_err on that same cycle must lose to the set.
        skip_ch  = -1;
        stall_ch = -1;
        base     = 16'h1000;
        pulse_clear();
        spi_cnt  = 0;
        samp_cnt = 0;
        fd_cnt   = 0;
        rsp_ch   = 0;
        @(posedge clk); #1 bus.enable = 1'b1;
        repeat (38) @(posedge clk);
        @(negedge clk);
        chk("ovr_before_second_tick", 32'(bus.overrun), 0);
        @(posedge clk); #1 bus.clear_err = 1'b1;
        @(posedge clk); #1 bus.clear_err = 1'b0;
        @(negedge clk);
        chk("ovr_set_beats_clear", 32'(bus.overrun), 1);
        pulse_clear();
        @(negedge clk);
        chk("ovr_clear_pulse", 32'(bus.overrun), 0);
        wait_frame("ovr_seq");
        @(posedge clk); #1 bus.enable = 1'b0;
        repeat (6) @(negedge clk);
        chk("ovr_seq_sample_count", 32'(samp_cnt), 4);

        // Asynchronous reset while waiting for channel 1 data.
        base     = 16'h3300;
        spi_cnt  = 0;
        samp_cnt = 0;
        fd_cnt   = 0;
        rsp_ch   = 0;
        @(posedge clk); #1 bus.enable = 1'b1;
        k = 0;
        while (!(bus.spi_en && bus.ch_sel == 2'd1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reached_ch1", 32'(bus.ch_sel), 1);
        repeat (2) @(negedge clk);
        #2 reset_b = 1'b0;
        #1 chk_reset("async_rst");
        bus.enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_b = 1'b1;
        rsp_ch   = 0;
        spi_cnt  = 0;
        samp_cnt = 0;
        fd_cnt   = 0;
        @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 0);
        chk("post_rst_sb_empty", 32'(sb.size()), 0);
        @(posedge clk); #1 bus.enable = 1'b1;
        wait_frame("post_rst");
        @(posedge clk); #1 bus.enable = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_spi_en_count", 32'(spi_cnt), 4);
        chk("post_rst_sample_count", 32'(samp_cnt), 4);
        chk("post_rst_sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
